// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: instruction-fetch front end. Owns the fetch PC, issues
// in-order instruction-memory reads, and buffers returned words in a small
// queue whose head feeds the IF/ID register. Any redirect (jal, taken
// branch, jalr) flushes the queue and marks every in-flight read for
// discard.
// Optional feature: define FETCH_PERF_EN to add the bubble/stall counters.
//
// Handshake: a read is accepted on a cycle where imem_req && imem_ready;
// imem_addr is held stable while imem_req is high and not accepted. Read
// data is taken on every cycle imem_rvalid is high (no back-pressure);
// responses return in request order.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        next_select,
  input  logic        branch_result,
  input  logic        jalr,
  input  logic [31:0] next_address,
  input  logic        load,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pre_address_pc,
  output logic [31:0] instruction_fetch,
  output logic        fetch_empty
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;   // queue occupancy 0..FIFO_DEPTH
  localparam int OW = PW + 2;   // live reads plus reads awaiting discard

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] drop_cnt_q, drop_cnt_d;
  logic [31:0]   pc_mem_q    [FIFO_DEPTH];
  logic [31:0]   instr_mem_q [FIFO_DEPTH];

  logic          redirect;
  logic          resp_valid;
  logic          resp_drop;
  logic          push;
  logic          pop;
  logic          accept;
  logic [OW-1:0] live;
  logic [OW-1:0] credit;
  logic [31:0]   tag_pc;

  assign redirect   = next_select | branch_result | jalr;
  assign resp_valid = imem_rvalid && (outstanding_q != '0);
  assign resp_drop  = resp_valid && (drop_cnt_q != '0);
  assign push       = resp_valid && !resp_drop && !redirect;
  assign pop        = !load && !redirect && (count_q != '0);

  // Credit counts queue slots already spoken for. A pop this cycle frees a
  // slot, which lets a single-cycle memory stream one read per cycle.
  assign live       = outstanding_q - drop_cnt_q;
  assign credit     = OW'(count_q) + live - OW'(pop);
  assign imem_req   = !rst && !redirect && (credit < OW'(FIFO_DEPTH));
  assign imem_addr  = fetch_pc_q;
  assign accept     = imem_req && imem_ready;

  // Once pending discards are gone, the oldest outstanding read was issued
  // 4*outstanding bytes behind the current fetch PC.
  assign tag_pc = fetch_pc_q - {{(30-OW){1'b0}}, outstanding_q, 2'b00};

  assign fetch_empty       = (count_q == '0);
  assign pre_address_pc    = fetch_empty ? 32'h0 : pc_mem_q[rd_ptr_q];
  assign instruction_fetch = fetch_empty ? NOP_INSTR : instr_mem_q[rd_ptr_q];

  // Next-state: redirect flushes the queue and retargets the PC; otherwise
  // normal push/pop/issue bookkeeping.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q - OW'(resp_valid);
    drop_cnt_d    = drop_cnt_q;
    if (redirect) begin
      fetch_pc_d = next_address;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      drop_cnt_d = outstanding_q - OW'(resp_valid);
    end else begin
      if (accept) begin
        fetch_pc_d    = fetch_pc_q + 32'd4;
        outstanding_d = outstanding_q - OW'(resp_valid) + OW'(1);
      end
      if (resp_drop) drop_cnt_d = drop_cnt_q - OW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // Queue storage; contents are qualified by count_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= tag_pc;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  // The credit rule makes a push into a full queue unreachable.
  assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == CW'(FIFO_DEPTH))));

  // Read data with nothing outstanding is a memory protocol error.
  assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (outstanding_q == '0)));

`ifdef FETCH_PERF_EN
  logic [31:0] bubble_cnt_q;
  logic [31:0] stall_cnt_q;

  // Saturating counters of bubble cycles and held-head stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (fetch_empty && !load && !redirect && (bubble_cnt_q != 32'hFFFF_FFFF))
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (load && !fetch_empty && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_bubble_cnt = bubble_cnt_q;
  assign perf_stall_cnt  = stall_cnt_q;
`endif

endmodule
